// File: rtl/colour_matrix_pkg.sv
// colour_matrix_pkg
// Shared types and constants for the RGB -> YPbPr/YCbCr converter:
//   - mode_e       : conversion mode (bypass, YPbPr full, YCbCr limited, user)
//   - commit_st_e  : commit FSM states
//   - bank address map for the 12-entry coefficient/offset banks
//   - fixed mode-1/mode-2 coefficients and offsets, clamp limits vs. DW
package colour_matrix_pkg;

  typedef enum logic [1:0] {
    ModeBypass = 2'd0,
    ModeYpbpr  = 2'd1,
    ModeYcbcr  = 2'd2,
    ModeUser   = 2'd3
  } mode_e;

  typedef enum logic {
    StSteady  = 1'b0,
    StPending = 1'b1
  } commit_st_e;

  // Bank layout: 0..8 rows Y,Pb,Pr x cols R,G,B; 9..11 offsets Y,Pb,Pr.
  localparam int unsigned BankSize  = 12;
  localparam int unsigned AddrOffY  = 9;
  localparam int unsigned AddrOffPb = 10;
  localparam int unsigned AddrOffPr = 11;

  // Full-range YPbPr, scale 128.
  function automatic int m1_coef(input int idx);
    case (idx)
      0:       return 38;
      1:       return 75;
      2:       return 15;
      3:       return -22;
      4:       return -42;
      5:       return 64;
      6:       return 64;
      7:       return -54;
      8:       return -10;
      default: return 0;
    endcase
  endfunction

  // Limited-range YCbCr, scale 128.
  function automatic int m2_coef(input int idx);
    case (idx)
      0:       return 33;
      1:       return 64;
      2:       return 13;
      3:       return -19;
      4:       return -37;
      5:       return 56;
      6:       return 56;
      7:       return -47;
      8:       return -9;
      default: return 0;
    endcase
  endfunction

  // row: 0 = Y, 1 = Pb/Cb, 2 = Pr/Cr
  function automatic int m1_offset(input int row, input int dw);
    return (row == 0) ? 0 : (1 << (dw - 1));
  endfunction

  function automatic int m2_offset(input int row, input int dw);
    return (row == 0) ? (16 << (dw - 8)) : (128 << (dw - 8));
  endfunction

  // Reset contents of both banks: the mode-1 matrix and offsets.
  function automatic int bank_default(input int addr, input int dw);
    return (addr < int'(AddrOffY)) ? m1_coef(addr) : m1_offset(addr - int'(AddrOffY), dw);
  endfunction

  function automatic int clamp_lo(input mode_e mode, input logic luma, input int dw);
    if (mode == ModeYcbcr) return 16 << (dw - 8);
    return 0;
  endfunction

  function automatic int clamp_hi(input mode_e mode, input logic luma, input int dw);
    if (mode == ModeYcbcr) return (luma ? 235 : 240) << (dw - 8);
    return (1 << dw) - 1;
  endfunction

endpackage

// File: rtl/colour_matrix_row.sv
// colour_matrix_row
// One output row of the colour matrix, three pipeline stages:
//   S1 multiply, S2 sum + offset + round, S3 shift + clamp (or bypass select).
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   i_red/i_green/i_blue         unsigned input components
//   i_coef_r/i_coef_g/i_coef_b   signed coefficients (1.0 = 2^CF)
//   i_offset                     unsigned output offset
//   i_mode                       mode the pixel entered under (travels with data)
//   i_bypass                     component passed through in bypass mode
//   o_data                       registered result
module colour_matrix_row
  import colour_matrix_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned CW     = 9,
  parameter int unsigned CF     = 7,
  parameter bit          IsLuma = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DW-1:0]        i_red,
  input  logic [DW-1:0]        i_green,
  input  logic [DW-1:0]        i_blue,
  input  logic signed [CW-1:0] i_coef_r,
  input  logic signed [CW-1:0] i_coef_g,
  input  logic signed [CW-1:0] i_coef_b,
  input  logic [DW-1:0]        i_offset,
  input  mode_e                i_mode,
  input  logic [DW-1:0]        i_bypass,
  output logic [DW-1:0]        o_data
);

  localparam int unsigned PW = DW + CW + 1;
  localparam int unsigned AW = DW + CW + 3;
  localparam logic signed [AW-1:0] Round = AW'(2 ** (CF - 1));

  logic signed [PW-1:0] r_prod_r, r_prod_g, r_prod_b;
  logic [DW-1:0]        r_off_s1, r_byp_s1, r_byp_s2;
  mode_e                r_mode_s1, r_mode_s2;
  logic signed [AW-1:0] r_acc;
  logic [DW-1:0]        r_out;

  logic signed [AW-1:0] w_sum, w_shift, w_lo, w_hi;
  logic [DW-1:0]        w_res;

  // Components are unsigned: a zero MSB keeps them positive in signed math.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod_r  <= '0;
      r_prod_g  <= '0;
      r_prod_b  <= '0;
      r_off_s1  <= '0;
      r_byp_s1  <= '0;
      r_mode_s1 <= ModeBypass;
    end else begin
      r_prod_r  <= i_coef_r * $signed({1'b0, i_red});
      r_prod_g  <= i_coef_g * $signed({1'b0, i_green});
      r_prod_b  <= i_coef_b * $signed({1'b0, i_blue});
      r_off_s1  <= i_offset;
      r_byp_s1  <= i_bypass;
      r_mode_s1 <= i_mode;
    end
  end

  always_comb begin
    w_sum = AW'(r_prod_r) + AW'(r_prod_g) + AW'(r_prod_b)
          + $signed({{(AW - DW - CF){1'b0}}, r_off_s1, {CF{1'b0}}}) + Round;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_byp_s2  <= '0;
      r_mode_s2 <= ModeBypass;
    end else begin
      r_acc     <= w_sum;
      r_byp_s2  <= r_byp_s1;
      r_mode_s2 <= r_mode_s1;
    end
  end

  always_comb begin
    w_shift = r_acc >>> CF;
    w_lo    = AW'(clamp_lo(r_mode_s2, IsLuma, int'(DW)));
    w_hi    = AW'(clamp_hi(r_mode_s2, IsLuma, int'(DW)));
    if (w_shift < w_lo) begin
      w_res = w_lo[DW-1:0];
    end else if (w_shift > w_hi) begin
      w_res = w_hi[DW-1:0];
    end else begin
      w_res = w_shift[DW-1:0];
    end
    if (r_mode_s2 == ModeBypass) begin
      w_res = r_byp_s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_res;
    end
  end

  assign o_data = r_out;

endmodule

// File: rtl/colour_matrix_conv.sv
// colour_matrix_conv
// Pipelined RGB -> YPbPr/YCbCr converter, fixed 3-clock latency in all modes.
// Ports:
//   clk, reset_n                      video clock, async active-low reset
//   mode_in                           requested mode (committed on vs rising edge)
//   coef_we/coef_addr/coef_data       shadow bank write port (addr >= 12 ignored)
//   red_in/green_in/blue_in           RGB pixel
//   hs_in/vs_in/cs_in/pixel_in        syncs and pixel strobe
//   red_out/green_out/blue_out        Pr/Cr, Y, Pb/Cb (R, G, B in bypass)
//   hs_out/vs_out/cs_out/pixel_out    syncs delayed 3 clocks
//   cfg_pending                       requested config not yet committed
module colour_matrix_conv
  import colour_matrix_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 9,
  parameter int unsigned CF = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    mode_in,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  input  logic [DW-1:0] red_in,
  input  logic [DW-1:0] green_in,
  input  logic [DW-1:0] blue_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          cs_in,
  input  logic          pixel_in,
  output logic [DW-1:0] red_out,
  output logic [DW-1:0] green_out,
  output logic [DW-1:0] blue_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          cs_out,
  output logic          pixel_out,
  output logic          cfg_pending
);

  logic [CW-1:0] r_shadow [BankSize];
  logic [CW-1:0] r_active [BankSize];
  mode_e         r_mode;
  commit_st_e    r_state;
  logic          r_cfg_pending;
  logic          r_vs_prev;
  logic [2:0][3:0] r_sync;

  logic                 w_vs_rise;
  logic signed [CW-1:0] w_coef [3][3];
  logic [DW-1:0]        w_off  [3];

  assign w_vs_rise = vs_in & ~r_vs_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_prev <= 1'b0;
      r_sync    <= '0;
    end else begin
      r_vs_prev <= vs_in;
      r_sync    <= {r_sync[1:0], {hs_in, vs_in, cs_in, pixel_in}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BankSize); i++) begin
        r_shadow[i] <= CW'(bank_default(i, int'(DW)));
      end
    end else if (coef_we && (coef_addr < 4'(BankSize))) begin
      r_shadow[coef_addr] <= coef_data;
    end
  end

  // Commit FSM. The active bank copies the shadow as it stood before this
  // cycle's write, so a write on the commit edge keeps the FSM pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StSteady;
      r_cfg_pending <= 1'b0;
      r_mode        <= ModeBypass;
      for (int i = 0; i < int'(BankSize); i++) begin
        r_active[i] <= CW'(bank_default(i, int'(DW)));
      end
    end else begin
      case (r_state)
        StSteady: begin
          if (coef_we || (mode_in != r_mode)) begin
            r_state       <= StPending;
            r_cfg_pending <= 1'b1;
          end
        end
        StPending: begin
          if (w_vs_rise) begin
            r_mode   <= mode_e'(mode_in);
            r_active <= r_shadow;
            if (!coef_we) begin
              r_state       <= StSteady;
              r_cfg_pending <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= StSteady;
          r_cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  // Matrix seen by the pixel entering stage 1 this cycle.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        case (r_mode)
          ModeYpbpr: w_coef[r][c] = CW'(m1_coef(r * 3 + c));
          ModeYcbcr: w_coef[r][c] = CW'(m2_coef(r * 3 + c));
          default:   w_coef[r][c] = r_active[r * 3 + c];
        endcase
      end
      case (r_mode)
        ModeYpbpr: w_off[r] = DW'(m1_offset(r, int'(DW)));
        ModeYcbcr: w_off[r] = DW'(m2_offset(r, int'(DW)));
        default:   w_off[r] = DW'(r_active[int'(AddrOffY) + r]);
      endcase
    end
  end

  colour_matrix_row #(
    .DW     (DW),
    .CW     (CW),
    .CF     (CF),
    .IsLuma (1'b1)
  ) u_row_y (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_red    (red_in),
    .i_green  (green_in),
    .i_blue   (blue_in),
    .i_coef_r (w_coef[0][0]),
    .i_coef_g (w_coef[0][1]),
    .i_coef_b (w_coef[0][2]),
    .i_offset (w_off[0]),
    .i_mode   (r_mode),
    .i_bypass (green_in),
    .o_data   (green_out)
  );

  colour_matrix_row #(
    .DW     (DW),
    .CW     (CW),
    .CF     (CF),
    .IsLuma (1'b0)
  ) u_row_pb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_red    (red_in),
    .i_green  (green_in),
    .i_blue   (blue_in),
    .i_coef_r (w_coef[1][0]),
    .i_coef_g (w_coef[1][1]),
    .i_coef_b (w_coef[1][2]),
    .i_offset (w_off[1]),
    .i_mode   (r_mode),
    .i_bypass (blue_in),
    .o_data   (blue_out)
  );

  colour_matrix_row #(
    .DW     (DW),
    .CW     (CW),
    .CF     (CF),
    .IsLuma (1'b0)
  ) u_row_pr (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_red    (red_in),
    .i_green  (green_in),
    .i_blue   (blue_in),
    .i_coef_r (w_coef[2][0]),
    .i_coef_g (w_coef[2][1]),
    .i_coef_b (w_coef[2][2]),
    .i_offset (w_off[2]),
    .i_mode   (r_mode),
    .i_bypass (red_in),
    .o_data   (red_out)
  );

  assign {hs_out, vs_out, cs_out, pixel_out} = r_sync[2];
  assign cfg_pending = r_cfg_pending;

endmodule

// File: tb/tb_colour_matrix_conv.sv
module tb_colour_matrix_conv;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode_in;
  logic       coef_we;
  logic [3:0] coef_addr;
  logic [8:0] coef_data;
  logic [7:0] red_in, green_in, blue_in;
  logic       hs_in, vs_in, cs_in, pixel_in;
  logic [7:0] red_out, green_out, blue_out;
  logic       hs_out, vs_out, cs_out, pixel_out, cfg_pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  colour_matrix_conv #(
    .DW (8),
    .CW (9),
    .CF (7)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode_in     (mode_in),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .cs_in       (cs_in),
    .pixel_in    (pixel_in),
    .red_out     (red_out),
    .green_out   (green_out),
    .blue_out    (blue_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .cs_out      (cs_out),
    .pixel_out   (pixel_out),
    .cfg_pending (cfg_pending)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] ri, gi, bi;
    logic [7:0] ro, go, bo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    red_in   = r;
    green_in = g;
    blue_in  = b;
  endtask

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic commit(input logic [1:0] m);
    mode_in = m;
    vs_in   = 1'b0;
    tick();
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    tick();
  endtask

  task automatic chk_rgb(input string name, input int r, input int g, input int b);
    chk({name, "_red"}, int'(red_out), r);
    chk({name, "_green"}, int'(green_out), g);
    chk({name, "_blue"}, int'(blue_out), b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int er [16], eg [16], eb [16], es [16];

    vecs[0] = '{"m0_bypass", 2'd0, 8'd12, 8'd34, 8'd56, 8'd12, 8'd34, 8'd56};
    vecs[1] = '{"m1_white",  2'd1, 8'd255, 8'd255, 8'd255, 8'd128, 8'd255, 8'd128};
    vecs[2] = '{"m1_red",    2'd1, 8'd255, 8'd0, 8'd0, 8'd255, 8'd76, 8'd84};
    vecs[3] = '{"m1_black",  2'd1, 8'd0, 8'd0, 8'd0, 8'd128, 8'd0, 8'd128};
    vecs[4] = '{"m1_green",  2'd1, 8'd0, 8'd255, 8'd0, 8'd20, 8'd149, 8'd44};
    vecs[5] = '{"m1_blue",   2'd1, 8'd0, 8'd0, 8'd255, 8'd108, 8'd30, 8'd255};
    vecs[6] = '{"m2_white",  2'd2, 8'd255, 8'd255, 8'd255, 8'd128, 8'd235, 8'd128};
    vecs[7] = '{"m2_black",  2'd2, 8'd0, 8'd0, 8'd0, 8'd128, 8'd16, 8'd128};
    vecs[8] = '{"m2_red",    2'd2, 8'd255, 8'd0, 8'd0, 8'd240, 8'd82, 8'd90};
    vecs[9] = '{"m0_mid",    2'd0, 8'd200, 8'd1, 8'd254, 8'd200, 8'd1, 8'd254};

    reset_n = 1'b0;
    mode_in = 2'd0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    pix(8'd0, 8'd0, 8'd0);
    {hs_in, vs_in, cs_in, pixel_in} = 4'b0;
    tick();
    tick();
    chk_rgb("reset", 0, 0, 0);
    chk("reset_syncs", int'({hs_out, vs_out, cs_out, pixel_out}), 0);
    chk("reset_pending", int'(cfg_pending), 0);
    reset_n = 1'b1;
    tick();

    // Streaming bypass: each output must match the input of 3 clocks before.
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        er[i] = (i * 7) & 255;
        eg[i] = (i * 11 + 3) & 255;
        eb[i] = 255 - i;
        es[i] = {28'd0, i % 3 == 0, i % 4 < 2, i % 5 == 1, i % 2 == 1};
        pix(8'(er[i]), 8'(eg[i]), 8'(eb[i]));
        {hs_in, vs_in, cs_in, pixel_in} = 4'(es[i]);
      end
      tick();
      if (i >= 2) begin
        chk_rgb($sformatf("stream%0d", i - 2), er[i-2], eg[i-2], eb[i-2]);
        chk($sformatf("stream%0d_syncs", i - 2), int'({hs_out, vs_out, cs_out, pixel_out}),
            es[i-2]);
      end
    end
    {hs_in, vs_in, cs_in, pixel_in} = 4'b0;
    tick();

    foreach (vecs[i]) begin
      commit(vecs[i].mode);
      pix(vecs[i].ri, vecs[i].gi, vecs[i].bi);
      tick();
      tick();
      tick();
      chk_rgb(vecs[i].name, int'(vecs[i].ro), int'(vecs[i].go), int'(vecs[i].bo));
    end

    // Mode change 1 -> 2 mid-frame: holds mode 1 until the vs rising edge.
    commit(2'd1);
    chk("m1_settled_pending", int'(cfg_pending), 0);
    pix(8'd255, 8'd255, 8'd255);
    mode_in = 2'd2;
    tick();
    chk("chg_pending_hi", int'(cfg_pending), 1);
    tick();
    tick();
    chk("chg_before_commit_green", int'(green_out), 255);
    vs_in = 1'b1;
    tick();
    pix(8'd0, 8'd0, 8'd0);
    tick();
    chk("chg_pending_lo", int'(cfg_pending), 0);
    tick();
    chk_rgb("chg_commit_pix", 128, 255, 128);
    tick();
    chk_rgb("chg_next_pix", 128, 16, 128);
    vs_in = 1'b0;
    tick();

    // User matrix routing R->Pr, G->Y, B->Pb, offsets zero.
    for (int a = 0; a < 12; a++) begin
      wr(4'(a), (a == 1 || a == 5 || a == 6) ? 9'd128 : 9'd0);
    end
    chk("user_wr_pending", int'(cfg_pending), 1);
    commit(2'd3);
    chk("user_commit_pending", int'(cfg_pending), 0);
    pix(8'd200, 8'd100, 8'd50);
    tick();
    tick();
    tick();
    chk_rgb("user_route", 200, 100, 50);

    wr(4'd0, 9'd255);
    wr(4'd12, 9'd77);
    commit(2'd3);
    pix(8'd255, 8'd0, 8'd0);
    tick();
    tick();
    tick();
    chk_rgb("user_clamp_hi", 255, 255, 0);

    wr(4'd0, 9'h100);
    commit(2'd3);
    pix(8'd100, 8'd0, 8'd0);
    tick();
    tick();
    tick();
    chk_rgb("user_clamp_lo", 100, 0, 0);

    // Write on the commit edge: lands in shadow, FSM stays pending.
    mode_in = 2'd3;
    vs_in = 1'b1;
    wr(4'd0, 9'd0);
    vs_in = 1'b0;
    tick();
    chk("commit_edge_wr_pending", int'(cfg_pending), 1);
    commit(2'd3);
    chk("commit_edge_wr_done", int'(cfg_pending), 0);

    // Async reset with data in flight.
    pix(8'd200, 8'd100, 8'd50);
    {hs_in, vs_in, cs_in, pixel_in} = 4'b1011;
    tick();
    tick();
    tick();
    tick();
    chk("pre_rst_red", int'(red_out), 200);
    #3;
    reset_n = 1'b0;
    #1;
    chk_rgb("async_rst", 0, 0, 0);
    chk("async_rst_syncs", int'({hs_out, vs_out, cs_out, pixel_out}), 0);
    {hs_in, vs_in, cs_in, pixel_in} = 4'b0;
    mode_in = 2'd0;
    tick();
    reset_n = 1'b1;
    pix(8'd12, 8'd34, 8'd56);
    tick();
    tick();
    tick();
    chk("post_rst_pending", int'(cfg_pending), 0);
    chk_rgb("post_rst_bypass", 12, 34, 56);
    commit(2'd3);
    pix(8'd255, 8'd255, 8'd255);
    tick();
    tick();
    tick();
    chk_rgb("post_rst_bank_default", 128, 255, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
